md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers, the successor to the fixed 32-bit, fixed-latency execute-stage multiply/divide helper.
- Sits beside the ALU in the execute stage; the EX/MEM pipeline register captures mfhi/mflo data from its hi/lo outputs.
- Adds configurable width and latency, multiply-accumulate modes, a flush/cancel input and a done pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request, sampled each rising edge.
- op  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; all other codes are no-op.
- a  in  WIDTH  operand A (rs), already forwarded.
- b  in  WIDTH  operand B (rt), already forwarded.
- flush  in  1  cancels the in-flight operation.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse in the cycle HI/LO first shows a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi, lo, busy and done go to 0.
  - The internal counter and latched result go to 0.
  - An in-flight operation is discarded.
- Accept: start=1, busy=0, flush=0 and op valid at edge t.
  - start while busy=1 is ignored; the requester stalls.
  - start with flush=1 in the same cycle is not accepted.
- Multi-cycle ops (1–4, 7–10):
  - At accept, latch the operands and the full 2·WIDTH result. For madd/msub, the result is {hi,lo} ± product, using the HI/LO values at the accept edge.
  - busy=1 from cycle t+1 through t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - At the edge ending cycle t+N: write hi/lo and clear busy. done=1 during cycle t+N+1 only.
  - Counter is loaded with N and decrements while busy.
- Arithmetic:
  - mult, madd and msub use signed operands; multu, maddu and msubu use unsigned.
  - Product is 2·WIDTH bits: hi = upper half, lo = lower half.
  - Accumulate wraps modulo 2^(2·WIDTH).
  - div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): lo = a, hi = 0.
  - Divide by zero (div/divu, b=0): busy and done behave normally, and hi/lo keep their prior values.
- mthi / mtlo:
  - Single cycle with no busy and no done.
  - hi (or lo) = a at the accept edge; the new value is visible from t+1.
  - Ignored while busy.
- Flush:
  - flush=1 while busy, at any edge before the write edge: busy clears at that edge, hi/lo stay unchanged, and done is not raised.
  - flush coinciding with the write edge also cancels.
  - flush while idle has no effect.
- No back-to-back overlap: a new start is only accepted in the done cycle or later. start in the done cycle is legal.
- Outputs are registered; hi/lo never show a partial result.

Test Plan:
- Reset, then start op=1 with a=0xFFFFFFFE (−2), b=3 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- op=3 with a=−7, b=2 → after 10 busy cycles, lo=0xFFFFFFFD (−3) and hi=0xFFFFFFFF (−1). Repeat with op=4, a=7, b=0 → hi/lo unchanged after busy drops.
- mthi a=1, mtlo a=2, then op=7 with a=3, b=4 → after 5 cycles, hi=1, lo=14. Then op=10 with a=1, b=14 → hi=1, lo=0.
- Start mult, assert flush in busy cycle 3 → busy=0 next cycle, hi/lo equal their pre-start values, no done pulse. Then start with flush=1 in the same cycle → not accepted.
- start held high during busy with different operands → only the first operation executes. mtlo while busy → ignored. A second start in the done cycle → accepted.
- Assert reset (low) mid-divide, asynchronously between edges → hi, lo, busy and done read 0 immediately, and remain 0 after release until the next accept.

Source files
------------

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the execute stage and md_unit
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide/accumulate unit with HI/LO registers
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               wr_q, wr_d;      // cleared for divide-by-zero so HI/LO are preserved
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_valid, is_div, sgn, accept;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, result;
    logic [WIDTH-1:0]   mag_a, mag_b, dvsr, qmag, rmag, quo, rem;

    // Result datapath: signed ops are handled by sign-extending to 2*WIDTH (multiply)
    // or by dividing magnitudes and restoring signs (divide). The min/-1 case falls out
    // naturally: the magnitude quotient 2^(WIDTH-1) negates back to itself.
    always_comb begin
        op_valid = (bus.op >= OP_MULT) && (bus.op <= OP_MSUBU);
        is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        sgn      = (bus.op == OP_MULT) || (bus.op == OP_MADD) ||
                   (bus.op == OP_MSUB) || (bus.op == OP_DIV);
        accept   = bus.start && !bus.flush && op_valid;

        ext_a = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
        ext_b = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
        prod  = ext_a * ext_b;
        acc   = {hi_q, lo_q};

        mag_a = (sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        mag_b = (sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
        dvsr  = (mag_b == '0) ? WIDTH'(1) : mag_b;
        qmag  = mag_a / dvsr;
        rmag  = mag_a % dvsr;
        quo   = (sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])) ? (~qmag + WIDTH'(1)) : qmag;
        rem   = (sgn && bus.a[WIDTH-1]) ? (~rmag + WIDTH'(1)) : rmag;

        case (bus.op)
            OP_MADD, OP_MADDU: result = acc + prod;
            OP_MSUB, OP_MSUBU: result = acc - prod;
            OP_DIV, OP_DIVU:   result = {rem, quo};
            default:           result = prod;
        endcase
    end

    // Next-state: accept in idle, count down while busy, commit or cancel at the end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        res_d   = result;
                        wr_d    = !(is_div && (bus.b == '0));
                    end
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (wr_q) begin
                        hi_d = res_q[2*WIDTH-1:WIDTH];
                        lo_d = res_q[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a transaction-level model
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: HI/LO plus one pending operation with an absolute due edge
    longint      edge_no = 0;
    longint      m_due   = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    bit          m_pend = 0, m_wr = 0, m_done = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_pend = 0; m_wr = 0; m_done = 0; m_res = '0;
    endtask

    task automatic model_step();
        longint sa, sb, ua, ub, q, r;
        logic [63:0] prod;
        edge_no++;
        m_done = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        sa = longint'($signed(bus.a));
        sb = longint'($signed(bus.b));
        ua = longint'({32'b0, bus.a});
        ub = longint'({32'b0, bus.b});
        if (m_pend) begin
            if (bus.flush) begin
                m_pend = 0;
            end else if (edge_no == m_due) begin
                m_pend = 0;
                m_done = 1;
                if (m_wr) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                end
            end
        end else if (bus.start && !bus.flush) begin
            case (bus.op)
                4'd5: m_hi = bus.a;
                4'd6: m_lo = bus.a;
                4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: begin
                    if (bus.op == 4'd1 || bus.op == 4'd7 || bus.op == 4'd9) prod = 64'(sa * sb);
                    else prod = 64'(ua * ub);
                    if (bus.op == 4'd7 || bus.op == 4'd8) m_res = {m_hi, m_lo} + prod;
                    else if (bus.op == 4'd9 || bus.op == 4'd10) m_res = {m_hi, m_lo} - prod;
                    else m_res = prod;
                    m_wr = 1; m_pend = 1; m_due = edge_no + MC;
                end
                4'd3, 4'd4: begin
                    m_wr = (bus.b != 0);
                    if (m_wr) begin
                        if (bus.op == 4'd3) begin q = sa / sb; r = sa % sb; end
                        else begin q = ua / ub; r = ua % ub; end
                        m_res = {r[31:0], q[31:0]};
                    end
                    m_pend = 1; m_due = edge_no + DC;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare();
        check("busy", 64'(bus.busy), 64'(m_pend));
        check("done", 64'(bus.done), 64'(m_done));
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit st, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit fl);
        bus.start = st; bus.op = op; bus.a = a; bus.b = b; bus.flush = fl;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n);
        drive(1, op, a, b, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        busy_n = int'(bus.busy);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.busy) break;
            tick();
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
        end
        check("op_timeout", 64'(bus.busy), 64'(0));
        tick();
        done_n += int'(bus.done);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bn, dn;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        reset = 1'b1;
        tick();

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, bn, dn);
        check("mult_busy_cycles", 64'(bn), 64'(MC));
        check("mult_done_pulses", 64'(dn), 64'(1));
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, bn, dn);
        check("div_busy_cycles", 64'(bn), 64'(DC));
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        run_op(4'd4, 32'd7, 32'd0, bn, dn);
        check("div0_busy_cycles", 64'(bn), 64'(DC));
        check("div0_done_pulses", 64'(dn), 64'(1));
        check("div0_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div0_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        drive(1, 4'd5, 32'd1, 32'd0, 0); tick();
        check("mthi_no_busy", 64'(bus.busy), 64'(0));
        drive(1, 4'd6, 32'd2, 32'd0, 0); tick();
        drive(0, 0, 0, 0, 0);
        check("mthi_hi", 64'(bus.hi), 64'(1));
        check("mtlo_lo", 64'(bus.lo), 64'(2));
        run_op(4'd7, 32'd3, 32'd4, bn, dn);
        check("madd_hi", 64'(bus.hi), 64'(1));
        check("madd_lo", 64'(bus.lo), 64'(14));
        run_op(4'd10, 32'd1, 32'd14, bn, dn);
        check("msubu_hi", 64'(bus.hi), 64'(1));
        check("msubu_lo", 64'(bus.lo), 64'(0));

        // flush in busy cycle 3
        drive(1, 4'd1, 32'd5, 32'd6, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_hilo", {32'(bus.hi), 32'(bus.lo)}, {32'd1, 32'd0});
        dn = 0;
        for (int k = 0; k < 8; k++) begin tick(); dn += int'(bus.done); end
        check("flush_no_done", 64'(dn), 64'(0));
        drive(1, 4'd1, 32'd5, 32'd6, 1); tick();
        drive(0, 0, 0, 0, 0);
        check("start_with_flush", 64'(bus.busy), 64'(0));

        // start held while busy, mtlo while busy, then restart in the done cycle
        drive(1, 4'd1, 32'd3, 32'd5, 0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'd2, $urandom, $urandom, 0); tick();
        end
        drive(1, 4'd6, 32'hAAAA, 32'd0, 0); tick();
        check("held_done", 64'(bus.done), 64'(1));
        check("held_lo", 64'(bus.lo), 64'(15));
        check("held_hi", 64'(bus.hi), 64'(0));
        drive(1, 4'd2, 32'd7, 32'd8, 0); tick();
        drive(0, 0, 0, 0, 0);
        check("done_cycle_accept", 64'(bus.busy), 64'(1));
        for (int k = 0; k < 10; k++) tick();
        check("b2b_lo", 64'(bus.lo), 64'(56));

        // asynchronous reset in the middle of a divide
        drive(1, 4'd3, 32'd100, 32'd7, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        @(posedge clk);
        model_step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_hi", 64'(bus.hi), 64'(0));
        check("arst_lo", 64'(bus.lo), 64'(0));
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        compare();
        tick();
        reset = 1'b1;
        tick(); tick();
        check("arst_after_lo", 64'(bus.lo), 64'(0));
        check("arst_after_busy", 64'(bus.busy), 64'(0));

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), pick(), pick(),
                  ($urandom_range(0, 11) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
